// File: rtl/jpeg_bitstream_unpacker.sv
// -----------------------------------------------------------------------------
// jpeg_bitstream_unpacker
//
// Reader-side counterpart to the 32-bit JPEG bitstream packer. Packed words are
// split into bytes, JPEG byte stuffing (0xFF 0x00 -> 0xFF) is removed, markers
// (0xFF followed by anything other than 0x00/0xFF) halt the stream, and the
// de-stuffed bits are served MSB-first as 1..MAX_RD bit reads to a downstream
// entropy decoder.
//
// Optional feature: define UNPACK_STATS_EN to add saturating statistics
// counters (stat_bytes_o, stat_stuffed_o, stat_markers_o). Without the macro
// those ports and counters do not exist.
//
// Parameters:
//   BUF_W  bit-buffer depth in bits (>= MAX_RD + 8)
//   MAX_RD maximum bits per read request (<= 16, the rd_data_o width)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   in_valid_i       input word valid
//   in_ready_o       unpacker can accept a word this cycle
//   in_data_i        packed word, byte [31:24] first in stream order
//   in_last_i        final word of the stream
//   in_last_bytes_i  valid bytes (1..4, left-aligned) in the final word
//   rd_valid_i       read request
//   rd_len_i         bits requested, 1..MAX_RD
//   rd_ready_o       request can complete this cycle (count >= rd_len_i)
//   rd_data_o        requested bits, right-aligned, upper bits zero
//   marker_valid_o   marker detected, byte processing halted
//   marker_code_o    byte that followed 0xFF
//   marker_clr_i     one-cycle pulse resuming after a marker
//   eos_o            stream ended and bit buffer empty
//   err_trunc_o      sticky: stream ended on a dangling 0xFF
//   stat_bytes_o     (UNPACK_STATS_EN) raw input bytes consumed
//   stat_stuffed_o   (UNPACK_STATS_EN) stuff bytes removed
//   stat_markers_o   (UNPACK_STATS_EN) markers detected
// -----------------------------------------------------------------------------
module jpeg_bitstream_unpacker #(
    parameter int BUF_W  = 32,
    parameter int MAX_RD = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    input  logic [2:0]  in_last_bytes_i,
    input  logic        rd_valid_i,
    input  logic [4:0]  rd_len_i,
    output logic        rd_ready_o,
    output logic [15:0] rd_data_o,
    output logic        marker_valid_o,
    output logic [7:0]  marker_code_o,
    input  logic        marker_clr_i,
    output logic        eos_o,
    output logic        err_trunc_o
`ifdef UNPACK_STATS_EN
    ,
    output logic [31:0] stat_bytes_o,
    output logic [15:0] stat_stuffed_o,
    output logic [7:0]  stat_markers_o
`endif
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FF_SEEN = 2'd1,
        ST_MARKER  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [31:0]        hold_data_q, hold_data_d;   // current byte at [31:24]
    logic [2:0]         hold_cnt_q, hold_cnt_d;     // bytes still to emit
    logic               fin_q, fin_d;               // final word accepted
    logic [BUF_W-1:0]   buf_q, buf_d;               // oldest bit at MSB
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         marker_code_q, marker_code_d;
    logic               err_trunc_q, err_trunc_d;

    // ------------------------------------------------------------------
    // Byte-stage helpers
    // ------------------------------------------------------------------
    logic [7:0]         byte_cur;
    logic               byte_avail;
    logic               stage_open;
    logic               end_reached;
    logic               byte_take;
    logic               append_en;
    logic [7:0]         append_byte;
    logic               marker_hit;
    logic               accept_ok;
    logic               in_load;

    assign byte_cur    = hold_data_q[31:24];
    assign byte_avail  = (hold_cnt_q != 3'd0);
    // Room for a whole byte is judged on the current count; a read in the
    // same cycle only frees more space.
    assign stage_open  = (count_q <= CNT_W'(BUF_W - 8));
    // The end flag is reached once the final word has emitted its last byte.
    assign end_reached = fin_q && !byte_avail;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        err_trunc_d = err_trunc_q;
        case (state_q)
            ST_RUN: begin
                if (end_reached) begin
                    state_d = ST_DONE;
                end else if (byte_take && (byte_cur == 8'hFF)) begin
                    state_d = ST_FF_SEEN;
                end
            end
            ST_FF_SEEN: begin
                if (end_reached) begin
                    // Stream ended between 0xFF and its partner byte.
                    state_d     = ST_DONE;
                    err_trunc_d = 1'b1;
                end else if (byte_take) begin
                    if (byte_cur == 8'h00) begin
                        state_d = ST_RUN;
                    end else if (byte_cur != 8'hFF) begin
                        state_d = ST_MARKER;
                    end
                    // 0xFF here is a fill byte: stay in FF_SEEN.
                end
            end
            ST_MARKER: begin
                if (marker_clr_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // ST_DONE is left only through reset.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control logic
    // ------------------------------------------------------------------
    always_comb begin
        byte_take      = 1'b0;
        append_en      = 1'b0;
        append_byte    = byte_cur;
        marker_hit     = 1'b0;
        accept_ok      = 1'b0;
        marker_valid_o = 1'b0;
        eos_o          = 1'b0;
        case (state_q)
            ST_RUN: begin
                byte_take = byte_avail && stage_open;
                append_en = byte_take && (byte_cur != 8'hFF);
                accept_ok = 1'b1;
            end
            ST_FF_SEEN: begin
                byte_take   = byte_avail && stage_open;
                // Only the stuffed 0x00 produces data, and the data is 0xFF.
                append_en   = byte_take && (byte_cur == 8'h00);
                append_byte = 8'hFF;
                marker_hit  = byte_take && (byte_cur != 8'h00) && (byte_cur != 8'hFF);
                accept_ok   = 1'b1;
            end
            ST_MARKER: begin
                marker_valid_o = 1'b1;
            end
            default: begin
                eos_o = (count_q == '0);
            end
        endcase
        // The holding register refills in the same cycle its last byte
        // leaves, so consecutive words stream without a bubble. Gating with
        // rst_n_i keeps in_ready low for as long as reset is held.
        in_ready_o = accept_ok && rst_n_i && !fin_q &&
                     (!byte_avail || ((hold_cnt_q == 3'd1) && byte_take));
    end

    assign in_load       = in_valid_i && in_ready_o;
    assign marker_code_o = marker_code_q;
    assign err_trunc_o   = err_trunc_q;

    // ------------------------------------------------------------------
    // Input holding register
    // ------------------------------------------------------------------
    logic [2:0] last_cnt;

    always_comb begin
        // Out-of-range byte counts on the final word are treated as a full word.
        last_cnt    = (in_last_bytes_i inside {3'd1, 3'd2, 3'd3}) ? in_last_bytes_i : 3'd4;
        hold_data_d = hold_data_q;
        hold_cnt_d  = hold_cnt_q;
        fin_d       = fin_q;
        if (byte_take) begin
            hold_data_d = {hold_data_q[23:0], 8'h00};
            hold_cnt_d  = hold_cnt_q - 3'd1;
        end
        if (in_load) begin
            hold_data_d = in_data_i;
            hold_cnt_d  = in_last_i ? last_cnt : 3'd4;
            fin_d       = in_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_data_q <= '0;
            hold_cnt_q  <= '0;
            fin_q       <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_cnt_q  <= hold_cnt_d;
            fin_q       <= fin_d;
        end
    end

    // ------------------------------------------------------------------
    // Bit buffer and read port
    // ------------------------------------------------------------------
    logic                len_ok;
    logic                rd_fire;
    logic [CNT_W-1:0]    rd_amt;
    logic [CNT_W-1:0]    rem_cnt;
    logic [BUF_W-1:0]    ins_word;
    logic [MAX_RD-1:0]   top_bits;
    logic [4:0]          rd_shamt;

    assign len_ok     = (rd_len_i != 5'd0) && (rd_len_i <= 5'(MAX_RD));
    assign rd_ready_o = len_ok && (count_q >= CNT_W'(rd_len_i));
    assign rd_fire    = rd_valid_i && rd_ready_o;

    assign top_bits   = buf_q[BUF_W-1 -: MAX_RD];
    assign rd_shamt   = 5'(MAX_RD) - rd_len_i;
    assign rd_data_o  = len_ok ? 16'(top_bits >> rd_shamt) : 16'd0;

    always_comb begin
        rd_amt   = rd_fire ? CNT_W'(rd_len_i) : '0;
        rem_cnt  = count_q - rd_amt;
        // New byte is placed directly below the bits that survive this
        // cycle's read; bits below count are kept zero so OR-ing is safe.
        ins_word = {append_byte, {(BUF_W - 8){1'b0}}} >> rem_cnt;
        buf_d    = buf_q << rd_amt;
        count_d  = rem_cnt;
        if (append_en) begin
            buf_d   = buf_d | ins_word;
            count_d = rem_cnt + CNT_W'(8);
        end
    end

    always_comb begin
        marker_code_d = marker_code_q;
        if (marker_hit) begin
            marker_code_d = byte_cur;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q         <= '0;
            count_q       <= '0;
            marker_code_q <= '0;
        end else begin
            buf_q         <= buf_d;
            count_q       <= count_d;
            marker_code_q <= marker_code_d;
        end
    end

`ifdef UNPACK_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [31:0] stat_bytes_q, stat_bytes_d;
    logic [15:0] stat_stuffed_q, stat_stuffed_d;
    logic [7:0]  stat_markers_q, stat_markers_d;

    always_comb begin
        stat_bytes_d   = stat_bytes_q;
        stat_stuffed_d = stat_stuffed_q;
        stat_markers_d = stat_markers_q;
        if (byte_take && (stat_bytes_q != '1)) begin
            stat_bytes_d = stat_bytes_q + 32'd1;
        end
        // An append from FF_SEEN is exactly a removed stuff byte.
        if (append_en && (state_q == ST_FF_SEEN) && (stat_stuffed_q != '1)) begin
            stat_stuffed_d = stat_stuffed_q + 16'd1;
        end
        if (marker_hit && (stat_markers_q != '1)) begin
            stat_markers_d = stat_markers_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_bytes_q   <= '0;
            stat_stuffed_q <= '0;
            stat_markers_q <= '0;
        end else begin
            stat_bytes_q   <= stat_bytes_d;
            stat_stuffed_q <= stat_stuffed_d;
            stat_markers_q <= stat_markers_d;
        end
    end

    assign stat_bytes_o   = stat_bytes_q;
    assign stat_stuffed_o = stat_stuffed_q;
    assign stat_markers_o = stat_markers_q;
`endif

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for jpeg_bitstream_unpacker. A byte-level de-stuffing
// model pushes the expected bit sequence (and expected marker codes) into
// queues as each word is accepted; every completed read pops and compares.
// -----------------------------------------------------------------------------
module tb_jpeg_bitstream_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        in_last_i = 1'b0;
    logic [2:0]  in_last_bytes_i = 3'd4;
    logic        rd_valid_i = 1'b0;
    logic [4:0]  rd_len_i = 5'd1;
    logic        rd_ready_o;
    logic [15:0] rd_data_o;
    logic        marker_valid_o;
    logic [7:0]  marker_code_o;
    logic        marker_clr_i = 1'b0;
    logic        eos_o;
    logic        err_trunc_o;
`ifdef UNPACK_STATS_EN
    logic [31:0] stat_bytes_o;
    logic [15:0] stat_stuffed_o;
    logic [7:0]  stat_markers_o;
`endif

    jpeg_bitstream_unpacker dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .in_last_i       (in_last_i),
        .in_last_bytes_i (in_last_bytes_i),
        .rd_valid_i      (rd_valid_i),
        .rd_len_i        (rd_len_i),
        .rd_ready_o      (rd_ready_o),
        .rd_data_o       (rd_data_o),
        .marker_valid_o  (marker_valid_o),
        .marker_code_o   (marker_code_o),
        .marker_clr_i    (marker_clr_i),
        .eos_o           (eos_o),
        .err_trunc_o     (err_trunc_o)
`ifdef UNPACK_STATS_EN
        ,
        .stat_bytes_o    (stat_bytes_o),
        .stat_stuffed_o  (stat_stuffed_o),
        .stat_markers_o  (stat_markers_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc_cnt = 0;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    bit         bit_q[$];     // expected de-stuffed bits, oldest first
    logic [7:0] mk_q[$];      // expected marker codes
    int         xfer_q[$];    // cycle stamps of accepted words
    bit         m_ff;
    bit         exp_trunc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push8(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
    endtask

    // Reference de-stuffing model, one raw byte at a time.
    task automatic model_byte(input logic [7:0] b);
        if (!m_ff) begin
            if (b == 8'hFF) m_ff = 1'b1;
            else push8(b);
        end else if (b == 8'h00) begin
            push8(8'hFF);
            m_ff = 1'b0;
        end else if (b != 8'hFF) begin
            mk_q.push_back(b);
            m_ff = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_last_i    = 1'b0;
        rd_valid_i   = 1'b0;
        rd_len_i     = 5'd1;
        marker_clr_i = 1'b0;
        bit_q.delete();
        mk_q.delete();
        xfer_q.delete();
        m_ff      = 1'b0;
        exp_trunc = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
        bit ok;
        int n;
        logic [31:0] w;
        ok = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        in_last_bytes_i = nb;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk_i);
            if (in_ready_o) ok = 1'b1;
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        if (!ok) begin
            chk("in_timeout", 32'd0, 32'd1);
        end else begin
            xfer_q.push_back(cyc_cnt);
            n = last ? int'(nb) : 4;
            w = d;
            for (int i = 0; i < n; i++) begin
                model_byte(w[31:24]);
                w = w << 8;
            end
            if (last) exp_trunc = m_ff;
            $display("word 0x%08h last=%0d bytes=%0d cyc=%0d", d, last, n, cyc_cnt);
        end
    endtask

    task automatic do_read(input logic [4:0] len);
        bit ok;
        logic [15:0] got;
        logic [15:0] exp;
        ok = 1'b0;
        got = '0;
        rd_valid_i = 1'b1;
        rd_len_i   = len;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk_i);
            if (rd_ready_o) begin
                ok  = 1'b1;
                got = rd_data_o;
            end
            @(posedge clk_i);
            #1;
        end
        rd_valid_i = 1'b0;
        if (!ok) begin
            chk("rd_timeout", 32'd0, 32'd1);
        end else if (bit_q.size() < int'(len)) begin
            chk("sb_underrun", bit_q.size(), 32'(len));
        end else begin
            exp = '0;
            for (int i = 0; i < int'(len); i++) exp = {exp[14:0], bit_q.pop_front()};
            chk("rd_data", 32'(got), 32'(exp));
            $display("read len=%0d data=0x%04h exp=0x%04h", len, got, exp);
        end
    endtask

    // sel: 0 marker_valid, 1 err_trunc, other eos. Ends just after a clock edge.
    task automatic wait_for(input int sel, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk_i);
            case (sel)
                0:       seen = marker_valid_o;
                1:       seen = err_trunc_o;
                default: seen = eos_o;
            endcase
            @(posedge clk_i);
            #1;
        end
    endtask

    logic [31:0] words[6];
    logic [7:0]  rb;
    bit          seen;

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("in_ready_in_rst", 32'(in_ready_o), 32'd0);
        do_reset();
        @(negedge clk_i);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        chk("rst_marker_valid", 32'(marker_valid_o), 32'd0);
        chk("rst_marker_code", 32'(marker_code_o), 32'd0);
        chk("rst_eos", 32'(eos_o), 32'd0);
        chk("rst_err_trunc", 32'(err_trunc_o), 32'd0);
        @(posedge clk_i);
        #1;

        // ---------------- plain word, latency, eos ----------------
        send_word(32'h12345678, 1'b1, 3'd4);
        rd_len_i = 5'd8;
        @(negedge clk_i);
        chk("lat_cycle1", 32'(rd_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("lat_cycle2", 32'(rd_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) do_read(5'd8);
        wait_for(2, seen);
        chk("t1_eos", 32'(seen), 32'd1);
        chk("t1_done_in_ready", 32'(in_ready_o), 32'd0);
        chk("t1_err_trunc", 32'(err_trunc_o), 32'(exp_trunc));

        // ---------------- stuffing removal ----------------
        do_reset();
        send_word(32'hABFF00CD, 1'b0, 3'd4);
        do_read(5'd16);
        do_read(5'd8);
`ifdef UNPACK_STATS_EN
        chk("t2_stat_stuffed", 32'(stat_stuffed_o), 32'd1);
        chk("t2_stat_bytes", stat_bytes_o, 32'd4);
`endif

        // ---------------- marker ----------------
        do_reset();
        send_word(32'h5AFFD900, 1'b0, 3'd4);
        wait_for(0, seen);
        chk("t3_marker_valid", 32'(seen), 32'd1);
        chk("t3_marker_code", 32'(marker_code_o), (mk_q.size() != 0) ? 32'(mk_q.pop_front()) : 32'hDEAD);
        chk("t3_in_ready_halted", 32'(in_ready_o), 32'd0);
        do_read(5'd8);
        rd_len_i = 5'd8;
        @(negedge clk_i);
        chk("t3_halted_no_data", 32'(rd_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        marker_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        marker_clr_i = 1'b0;
        chk("t3_marker_cleared", 32'(marker_valid_o), 32'd0);
        do_read(5'd8);
`ifdef UNPACK_STATS_EN
        chk("t3_stat_markers", 32'(stat_markers_o), 32'd1);
        chk("t3_stat_bytes", stat_bytes_o, 32'd4);
`endif

        // ---------------- truncated on dangling 0xFF ----------------
        do_reset();
        send_word(32'h77FF1234, 1'b1, 3'd2);
        wait_for(1, seen);
        chk("t4_err_trunc", 32'(err_trunc_o), 32'(exp_trunc));
        do_read(5'd8);
        rd_len_i = 5'd1;
        @(negedge clk_i);
        chk("t4_nothing_left", 32'(rd_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        wait_for(2, seen);
        chk("t4_eos", 32'(seen), 32'd1);

        // ---------------- back-to-back words, continuous reads ----------------
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 4; b++) begin
                rb = 8'($urandom_range(0, 255));
                if (rb == 8'hFF) rb = 8'hFE;
                words[k] = {words[k][23:0], rb};
            end
        end
        fork
            begin
                for (int k = 0; k < 6; k++) send_word(words[k], k == 5, 3'd4);
            end
            begin
                for (int k = 0; k < 38; k++) do_read(5'd5);
                do_read(5'd2);
            end
        join
        if (xfer_q.size() >= 2) chk("t5_no_bubble_gap", 32'(xfer_q[1] - xfer_q[0]), 32'd4);
        else chk("t5_word_count", 32'(xfer_q.size()), 32'd6);
        wait_for(2, seen);
        chk("t5_eos", 32'(seen), 32'd1);
        chk("t5_sb_drained", 32'(bit_q.size()), 32'd0);

        // ---------------- reset mid-stream ----------------
        do_reset();
        send_word(32'h11223344, 1'b1, 3'd3);
        do_read(5'd4);
        @(posedge clk_i);
        #1;
        rd_len_i = 5'd16;
        #1;
        chk("t6_count_ge16", 32'(rd_ready_o), 32'd1);
        rd_len_i = 5'd1;
        rst_n_i  = 1'b0;
        #1;
        chk("t6_rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("t6_rst_rd_data", 32'(rd_data_o), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("t6_rst_eos", 32'(eos_o), 32'd0);
        chk("t6_rst_marker", 32'(marker_valid_o), 32'd0);
        chk("t6_rst_err_trunc", 32'(err_trunc_o), 32'd0);
        bit_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t6_post_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("t6_post_in_ready", 32'(in_ready_o), 32'd1);
        chk("t6_post_eos", 32'(eos_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
